ucbus_responder: RTL
====================

// Module: ucbus_responder
// PURPOSE
//  Responder end of the uncached cbus path. The ROB drives cbus_req_t as initiator and
//  holds ureq.valid while the uncached load/store sits at the head; this block serves it.
//  Each request is latched and split into single-beat transactions on a simple memory port.
//  Every beat is returned as a one-cycle uresp.ready pulse; uresp.last marks the final beat.
//  Sits between the ROB and the uncached AXI/MMIO side.
// PARAMETERS
//  ADDR_W        64    request/memory address width
//  DATA_W        64    data width; strobe width is DATA_W/8
//  TIMEOUT       255   max WAIT cycles per beat before an error beat is returned (0 = off)
// PORTS
//  clk           in   1         clock
//  reset         in   1         asynchronous, active-high reset
//  req_valid     in   1         ureq.valid; held by initiator until its last beat returns
//  req_is_write  in   1         ureq.is_write
//  req_size      in   3         ureq.size; bytes per beat = 1<<size
//  req_addr      in   ADDR_W    ureq.addr
//  req_strobe    in   DATA_W/8  ureq.strobe
//  req_data      in   DATA_W    ureq.data; write data, same for all beats
//  req_len       in   4         ureq.len; beats = len+1 (MLEN1 = 0)
//  req_burst     in   2         ureq.burst: 0 FIXED, 1 INCR; other codes behave as FIXED
//  resp_ready    out  1         uresp.ready; one-cycle pulse per completed beat
//  resp_last     out  1         uresp.last; high with resp_ready on the final beat only
//  resp_data     out  DATA_W    uresp.data; read data of the beat, valid while resp_ready
//  resp_err      out  1         high with resp_ready when the beat timed out
//  m_req_valid   out  1         memory request valid
//  m_req_ready   in   1         memory request accepted when valid&&ready
//  m_is_write    out  1         latched is_write
//  m_addr        out  ADDR_W    current beat address
//  m_size        out  3         latched size
//  m_strobe      out  DATA_W/8  latched strobe; all 0 for reads
//  m_wdata       out  DATA_W    latched write data
//  m_resp_valid  in   1         memory response for the outstanding beat
//  m_rdata       in   DATA_W    memory read data, sampled with m_resp_valid
// BEHAVIOUR
//  - Reset (async): state=IDLE, beat counter=0, timeout counter=0.
//    Reset values: all outputs 0, m_addr 0, resp_data 0.
//    Reset mid-transaction abandons the transaction; no response is issued.
//  - IDLE: on req_valid, latch all req_* fields and set beats_left=req_len -> ISSUE.
//    No response is produced in the capture cycle.
//  - ISSUE: m_req_valid=1, with fields driven from registers only.
//    When m_req_ready is high -> WAIT and clear the timeout counter; otherwise stay.
//  - WAIT: m_req_valid=0. When m_resp_valid is high, register m_rdata -> RESP.
//    The timeout counter increments each WAIT cycle. At count==TIMEOUT-1 without
//    m_resp_valid: go to RESP with resp_data='1 and resp_err=1. A m_resp_valid seen in
//    that same cycle wins: normal data, err=0. A late m_resp_valid after a timeout is
//    ignored until the block is back in WAIT.
//  - RESP (1 cycle): resp_ready=1 and resp_last=(beats_left==0).
//    If last -> IDLE; otherwise decrement beats_left, advance m_addr, -> ISSUE.
//    m_addr advance: INCR adds 1<<size (ADDR_W wrap-around); FIXED keeps the address.
//  - Minimum latency from req_valid seen in IDLE to resp_ready is 3 cycles, given
//    m_req_ready on the ISSUE cycle and m_resp_valid on the first WAIT cycle.
//  - The initiator drops req_valid only after the last beat. A req_valid still high in
//    IDLE the cycle after a last pulse is a NEW request (the next ROB head) and is
//    captured. req_* changes during a transaction are ignored.
//  - Back-to-back: IDLE on the cycle after RESP(last) is mandatory. Never respond twice
//    to one capture.
//  - m_resp_valid outside WAIT is ignored.
// TESTING
//  1 Single read: size=3, addr=0x1000_0000, len=0; mem ready immediately, resp after
//    2 cycles with 0xDEAD_BEEF -> one ready&last pulse, data=0xDEAD_BEEF, err=0.
//  2 Write INCR: len=3, size=2, addr=0x100 -> m_addr 0x100,0x104,0x108,0x10C.
//    Four ready pulses; last only on the 4th; m_strobe/m_wdata constant.
//  3 FIXED burst, len=1 -> both beats at the same address; m_req_ready low 5 cycles
//    -> m_req_valid held 5+1 cycles, no ready pulse until accepted.
//  4 Timeout: TIMEOUT=8, no m_resp_valid -> ready&last&err after 8 WAIT cycles,
//    data=all 1s. A later m_resp_valid is ignored.
//  5 Back-to-back: req_valid held across two requests -> second captured the cycle after
//    the first last pulse; exactly 2 m_req handshakes and 2 last pulses.
//  6 Async reset asserted in WAIT -> outputs 0 immediately; after release, IDLE with no
//    stray ready.

Source files
------------

// File: rtl/ucbus_responder_if.sv
// Uncached cbus request/response bundle plus the single-beat memory port behind it.
// slave is the responder's view; master is the view of the ROB/memory environment.
interface ucbus_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_is_write;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [STRB_W-1:0] req_strobe;
  logic [DATA_W-1:0] req_data;
  logic [3:0]        req_len;
  logic [1:0]        req_burst;

  logic              resp_ready;
  logic              resp_last;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic              m_req_valid;
  logic              m_req_ready;
  logic              m_is_write;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [STRB_W-1:0] m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_resp_valid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    output resp_ready, resp_last, resp_data, resp_err,
    output m_req_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
    input  m_req_ready, m_resp_valid, m_rdata
  );

  modport master (
    output req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    input  resp_ready, resp_last, resp_data, resp_err,
    input  m_req_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
    output m_req_ready, m_resp_valid, m_rdata
  );
endinterface

// File: rtl/ucbus_responder.sv
// Responder for uncached ROB requests: latches one request and replays it as
// single-beat memory transactions, returning one ready pulse per beat.
module ucbus_responder #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  ucbus_responder_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              is_write_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [STRB_W-1:0] strobe_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        beats_left_q;
  logic [1:0]        burst_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic timeout_hit;
  logic last_beat;

  assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);
  assign last_beat   = (beats_left_q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid)   state_d = ISSUE;
      ISSUE:   if (bus.m_req_ready) state_d = WAIT;
      WAIT:    if (bus.m_resp_valid || timeout_hit) state_d = RESP;
      RESP:    state_d = last_beat ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.m_req_valid = (state_q == ISSUE);
    bus.m_is_write  = is_write_q;
    bus.m_addr      = addr_q;
    bus.m_size      = size_q;
    bus.m_strobe    = strobe_q;
    bus.m_wdata     = wdata_q;
    bus.resp_ready  = (state_q == RESP);
    bus.resp_last   = (state_q == RESP) && last_beat;
    bus.resp_err    = (state_q == RESP) && err_q;
    bus.resp_data   = rdata_q;
  end

  // A response arriving on the timeout cycle takes priority over the error beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write_q   <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      beats_left_q <= '0;
      burst_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            is_write_q   <= bus.req_is_write;
            size_q       <= bus.req_size;
            addr_q       <= bus.req_addr;
            strobe_q     <= bus.req_is_write ? bus.req_strobe : '0;
            wdata_q      <= bus.req_data;
            beats_left_q <= bus.req_len;
            burst_q      <= bus.req_burst;
            err_q        <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.m_req_ready) to_cnt_q <= '0;
        end
        WAIT: begin
          if (bus.m_resp_valid) begin
            rdata_q <= bus.m_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        RESP: begin
          if (!last_beat) begin
            beats_left_q <= beats_left_q - 4'd1;
            if (burst_q == 2'd1) addr_q <= addr_q + (ADDR_W'(1) << size_q);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
